// File: rtl/wb_burst_initiator.sv
// Wishbone B3 burst master: accepts single/incrementing-burst commands on a
// valid/ready port, sources write data from a stream, returns per-beat read
// data (or one write status) as response pulses. cyc and stb are one signal.
module wb_burst_initiator #(
  parameter int unsigned AW      = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned LW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_data_o,
  output logic            rsp_last_o,
  output logic            rsp_err_o,
  output logic            busy_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = 16;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WFETCH,
    S_BUS,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [LW-1:0]   beats_q, beats_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            cyc_q, cyc_d;
  logic [2:0]      cti_q, cti_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_last_q, rsp_last_d;
  logic            rsp_err_q, rsp_err_d;

  logic ack, err, timeout, final_beat;

  // Bus events only count while a cycle is open; err takes priority over ack.
  assign ack        = cyc_q & wb_ack_i & ~wb_err_i;
  assign err        = cyc_q & wb_err_i;
  assign timeout    = cyc_q & ~wb_ack_i & ~wb_err_i & (tmo_q == TW'(TIMEOUT - 1));
  assign final_beat = (beats_q == '0);

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      beats_q     <= '0;
      dat_q       <= '0;
      cyc_q       <= 1'b0;
      cti_q       <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      beats_q     <= beats_d;
      dat_q       <= dat_d;
      cyc_q       <= cyc_d;
      cti_q       <= cti_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state, bus sequencing and response generation.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    beats_d      = beats_q;
    dat_d        = dat_q;
    cyc_d        = cyc_q;
    cti_d        = cti_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = '0;
    rsp_last_d   = 1'b0;
    rsp_err_d    = 1'b0;
    wdat_ready_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          sel_d   = cmd_sel_i;
          beats_d = cmd_len_i;
          if (cmd_we_i) begin
            state_d = S_WFETCH;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            cti_d   = (cmd_len_i != '0) ? CTI_INC : CTI_CLASSIC;
            tmo_d   = '0;
          end
        end
      end

      S_WFETCH: begin
        wdat_ready_o = 1'b1;
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          state_d = S_BUS;
          cyc_d   = 1'b1;
          cti_d   = final_beat ? CTI_CLASSIC : CTI_INC;
          tmo_d   = '0;
        end
      end

      S_BUS: begin
        if (err || timeout) begin
          // Abort: report once, close the cycle, drop the remaining beats.
          cyc_d       = 1'b0;
          cti_d       = CTI_CLASSIC;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          state_d     = (we_q && !final_beat) ? S_DRAIN : S_IDLE;
        end else if (ack) begin
          tmo_d   = '0;
          addr_d  = addr_q + AW'(SW);
          beats_d = beats_q - LW'(1);
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = wb_dat_i;
            rsp_last_d  = final_beat;
          end
          if (final_beat) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = S_IDLE;
            if (we_q) begin
              rsp_valid_d = 1'b1;
              rsp_last_d  = 1'b1;
            end
          end else begin
            // An earlier beat of this cycle has now acked, so the last one is end-of-burst.
            cti_d = (beats_q != LW'(1)) ? CTI_INC : CTI_EOB;
            if (we_q) begin
              wdat_ready_o = 1'b1;
              if (wdat_valid_i) begin
                dat_d = wdat_i;
              end else begin
                cyc_d   = 1'b0;
                cti_d   = CTI_CLASSIC;
                state_d = S_WFETCH;
              end
            end
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DRAIN: begin
        wdat_ready_o = 1'b1;
        if (wdat_valid_i) begin
          beats_d = beats_q - LW'(1);
          if (beats_q == LW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_cti_o    = cti_q;
  assign wb_bte_o    = 2'b00;

endmodule
